pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Consumes decoded control from ID and EX (MemRead, RegWrite, rd/rs fields, resolved redirect) plus the data-memory handshake.
- Drives per-stage enable/flush strobes, a sticky memory-timeout error, and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before entering ERR (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  instruction in ID reads rs1.
- id_uses_rs2  in  1  instruction in ID reads rs2 (R/S/B types).
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  MemRead of the instruction in EX.
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX this cycle.
- dmem_req  in  1  MEM stage holds a load/store (MemRead|MemWrite).
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX loads a bubble (all control zero).
- exmem_en  out  1  EX/MEM register enable.
- memwb_flush  out  1  MEM/WB loads a bubble (RegWrite=0).
- mem_err  out  1  sticky timeout error.
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside reset.
- flush_cnt  out  CNT_W  cycles in which a redirect flush was issued.

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Reset → RUN, wait_cnt=0, mem_err=0, counters=0.
- Strobes are combinational from state and inputs.
- While rst=1: all *_en=0, ifid_flush=idex_flush=memwb_flush=1.
- Signal definitions:
  - mem_stall = dmem_req & ~dmem_ready.
  - load_use = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - x0 never creates a hazard.
- Priority, highest first: ERR > mem_stall > ex_redirect > load_use > normal.
- ERR:
  - All *_en=0, all flush=0 except memwb_flush=1.
  - mem_err=1.
  - Left only by rst.
- Freeze (mem_stall in RUN or MEM_WAIT):
  - pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1, so MEM/WB does not duplicate the writeback.
  - ifid_flush=idex_flush=0.
  - ex_redirect and load_use are ignored this cycle. EX is frozen, so both re-evaluate on the release cycle.
- RUN with mem_stall:
  - Freeze this cycle.
  - Next state MEM_WAIT, wait_cnt←1.
- MEM_WAIT:
  - dmem_ready=0: freeze and wait_cnt++. If wait_cnt==MEM_TIMEOUT-1 while still not ready, next state is ERR. Total frozen cycles then equal MEM_TIMEOUT.
  - dmem_ready=1: release cycle. Normal RUN evaluation applies (redirect/load_use may act the same cycle); next state RUN, wait_cnt←0.
  - dmem_req dropping while in MEM_WAIT is treated as ready.
- Redirect (no freeze):
  - pc_en=1 (PC takes target); ifid_flush=1, idex_flush=1.
  - ifid_en=idex_en=exmem_en=1.
  - load_use is suppressed because the younger instruction is squashed.
- Load-use (no freeze, no redirect):
  - pc_en=0, ifid_en=0; idex_flush=1; exmem_en=1.
  - Exactly one bubble: the next cycle the load is in MEM, so ex_mem_read refers to the bubble.
- Normal: all *_en=1, all flush=0.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_en=0 (freeze, load-use, ERR).
  - flush_cnt increments on each redirect cycle.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle; rst clears both.
- mem_err is only cleared by rst; cnt_clr does not affect it.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle all enables 1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Redirect with coincident load_use: ex_redirect=1 → ifid_flush=idex_flush=1, pc_en=1, no stall; flush_cnt=1, stall_cnt=0.
- Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high → 3 freeze cycles with memwb_flush=1, release on the 4th, state RUN; stall_cnt=3.
- Freeze hiding redirect: ex_redirect=1 held during a 2-cycle mem_stall → no flush during freeze; flush asserted on the release cycle; flush_cnt=1.
- Timeout (MEM_TIMEOUT=4): dmem_req=1, dmem_ready=0 forever → ERR after 4 frozen cycles, mem_err=1 held. Then dmem_ready=1 → still ERR. Then rst pulse → RUN, mem_err=0, counters 0.
- Counter saturation/clear (CNT_W=4): force 20 stall cycles → stall_cnt=15. cnt_clr asserted together with a stall → stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RISC-V pipeline: load-use bubbles,
// redirect squashes, data-memory freeze with timeout, and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_stall;
  logic load_use;
  logic redirect_fire;

  assign mem_stall = dmem_req & ~dmem_ready;

  // x0 is hardwired to zero, so a load targeting it can never feed ID.
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign redirect_fire = ~rst & (state_q != ERR) & ~mem_stall & ex_redirect;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first; a path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        // A dropped request counts as completion, so only mem_stall matters.
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == ERR || mem_stall) begin
      // Freeze: MEM/WB takes a bubble so the stalled writeback is not repeated.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (redirect_fire && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign mem_err   = (state_q == ERR);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4); a driver
// queues hand-computed expectations and a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  localparam logic [6:0] S_RST = 7'b0010101;
  localparam logic [6:0] S_NRM = 7'b1101010;
  localparam logic [6:0] S_FRZ = 7'b0000001;
  localparam logic [6:0] S_RED = 7'b1111110;
  localparam logic [6:0] S_LU  = 7'b0001110;

  typedef struct packed {
    logic [6:0] strb;
    int         sc;   // -1 skips the check
    int         fc;
    int         ee;
  } exp_t;

  logic clk = 1'b0;
  logic rst, cnt_clr, dmem_req, dmem_ready, ex_redirect, ex_mem_read;
  logic id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_flush(memwb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic step(input string nm, input logic r, input logic clr,
                      input logic req, input logic rdy, input logic redir,
                      input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [6:0] strb, input int sc, input int fc, input int ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cnt_clr = clr; dmem_req = req; dmem_ready = rdy;
    ex_redirect = redir; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    e.strb = strb; e.sc = sc; e.fc = fc; e.ee = ee;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic clr, input logic [6:0] strb,
                      input int sc, input int fc, input int ee);
    step(nm, 1'b0, clr, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
         strb, sc, fc, ee);
  endtask

  task automatic mem(input string nm, input logic rdy, input logic redir,
                     input logic [6:0] strb, input int sc, input int fc, input int ee);
    step(nm, 1'b0, 1'b0, 1'b1, rdy, redir, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
         strb, sc, fc, ee);
  endtask

  // Monitor: every cycle presents a strobe set, compared mid-cycle.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".strobes"}, int'({pc_en, ifid_en, ifid_flush, idex_en,
                                      idex_flush, exmem_en, memwb_flush}), int'(e.strb));
        if (e.sc >= 0) check({nm, ".stall_cnt"}, int'(stall_cnt), e.sc);
        if (e.fc >= 0) check({nm, ".flush_cnt"}, int'(flush_cnt), e.fc);
        if (e.ee >= 0) check({nm, ".mem_err"}, int'(mem_err), e.ee);
      end
    end
  end

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    ex_redirect = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

    // Reset strobes, then reset state.
    step("rst0", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, S_RST, -1, -1, -1);
    step("rst1", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, S_RST, 0, 0, 0);

    // Load-use on rs1, x0 immunity, rs2 match with and without uses_rs2.
    step("lu_rs1", 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, S_LU, 0, 0, 0);
    idle("lu_after", 0, S_NRM, 1, 0, 0);
    step("lu_x0", 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, S_NRM, 1, 0, 0);
    step("lu_rs2", 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, S_LU, 1, 0, 0);
    step("lu_rs2_unused", 0, 0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, S_NRM, 2, 0, 0);

    // Redirect beats a coincident load-use.
    idle("clr", 1, S_NRM, 2, 0, 0);
    step("redir_lu", 0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, S_RED, 0, 0, 0);
    idle("redir_after", 0, S_NRM, 0, 1, 0);

    // Three-cycle memory wait, release, then a fresh wait to show RUN/wait_cnt=0.
    mem("mw1", 0, 0, S_FRZ, 0, 1, 0);
    mem("mw2", 0, 0, S_FRZ, 1, 1, 0);
    mem("mw3", 0, 0, S_FRZ, 2, 1, 0);
    mem("mw_rel", 1, 0, S_NRM, 3, 1, 0);
    mem("mw_again", 0, 0, S_FRZ, 3, 1, 0);
    mem("mw_again_rel", 1, 0, S_NRM, 4, 1, 0);
    idle("mw_idle", 0, S_NRM, 4, 1, 0);

    // Freeze hides a held redirect until the release cycle.
    mem("fz_red1", 0, 1, S_FRZ, 4, 1, 0);
    mem("fz_red2", 0, 1, S_FRZ, 5, 1, 0);
    mem("fz_red_rel", 1, 1, S_RED, 6, 1, 0);
    idle("fz_red_idle", 0, S_NRM, 6, 2, 0);

    // Freeze hides load-use; dropping dmem_req releases and load-use acts.
    step("fz_lu", 0, 0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, S_FRZ, 6, 2, 0);
    step("drop_req_lu", 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, S_LU, 7, 2, 0);
    idle("drop_idle", 0, S_NRM, 8, 2, 0);

    // Timeout after four frozen cycles, ERR is sticky, cnt_clr spares mem_err.
    mem("to1", 0, 0, S_FRZ, 8, 2, 0);
    mem("to2", 0, 0, S_FRZ, 9, 2, 0);
    mem("to3", 0, 0, S_FRZ, 10, 2, 0);
    mem("to4", 0, 0, S_FRZ, 11, 2, 0);
    mem("err_hold", 0, 0, S_FRZ, 12, 2, 1);
    mem("err_ready_redir", 1, 1, S_FRZ, 13, 2, 1);
    idle("err_clr", 1, S_FRZ, 14, 2, 1);
    idle("err_after_clr", 0, S_FRZ, 0, 0, 1);
    step("err_rst", 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, S_RST, 1, 0, -1);
    idle("post_rst", 0, S_NRM, 0, 0, 0);

    // Twenty load-use stalls saturate the 4-bit counter at 15.
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0,
           S_LU, (i < 15) ? i : 15, 0, 0);
    idle("sat_hold", 0, S_NRM, 15, 0, 0);
    step("clr_with_stall", 0, 1, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, S_LU, 15, 0, 0);
    idle("clr_result", 0, S_NRM, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
